ss_pkt_arbiter: RTL and testbench

//  Packet-granular round-robin arbiter/mux: merges NUM_INPUTS ss slave streams onto one ss master stream.
//  A grant is held for a whole packet, from its first word through its last word, so packets never interleave.

---
 rtl/ss_pkt_arbiter.sv | 128 ++++++++++++
 tb/tb_ss_pkt_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ss_pkt_arbiter.sv
// Packet-granular round-robin merge of NUM_INPUTS ss streams onto one ss master stream.
// Latency: one IDLE arbitration cycle per packet, then zero-cycle combinational pass-through.
// Backpressure: m_ready reaches only the granted input's s_ready; all other inputs see s_ready=0.
module ss_pkt_arbiter #(
  parameter int NUM_INPUTS = 4,
  parameter int NUM_BYTES  = 1,
  parameter int USER_BITS  = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_INPUTS-1:0]               s_valid,
  output logic [NUM_INPUTS-1:0]               s_ready,
  input  logic [NUM_INPUTS*NUM_BYTES*8-1:0]   s_data,
  input  logic [NUM_INPUTS*NUM_BYTES-1:0]     s_keep,
  input  logic [NUM_INPUTS-1:0]               s_last,
  input  logic [NUM_INPUTS*USER_BITS-1:0]     s_user,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic [NUM_BYTES*8-1:0]              m_data,
  output logic [NUM_BYTES-1:0]                m_keep,
  output logic                                m_last,
  output logic [USER_BITS-1:0]                m_user,
  output logic [$clog2(NUM_INPUTS)-1:0]       grant,
  output logic                                busy
);

  localparam int DW = NUM_BYTES * 8;
  localparam int GW = $clog2(NUM_INPUTS);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t          r_state;
  logic [GW-1:0]   r_grant;
  logic [GW-1:0]   r_rr_ptr;

  logic            w_found;
  logic [GW-1:0]   w_winner;
  logic [GW-1:0]   w_cand;
  int              w_idx;

  logic            w_sel_valid;
  logic [DW-1:0]   w_sel_data;
  logic [NUM_BYTES-1:0] w_sel_keep;
  logic            w_sel_last;
  logic [USER_BITS-1:0] w_sel_user;
  logic [NUM_INPUTS-1:0] w_ready;

  // Round-robin search: first valid input after the one served last, wrapping modulo NUM_INPUTS.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    w_cand   = '0;
    for (int k = 1; k <= NUM_INPUTS; k++) begin
      w_idx  = (int'(r_rr_ptr) + k) % NUM_INPUTS;
      w_cand = GW'(w_idx);
      if (!w_found && s_valid[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  // Select the granted input's fields; mux driven only by the registered grant.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_data  = '0;
    w_sel_keep  = '0;
    w_sel_last  = 1'b0;
    w_sel_user  = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (GW'(i) == r_grant) begin
        w_sel_valid = s_valid[i];
        w_sel_data  = s_data[i*DW +: DW];
        w_sel_keep  = s_keep[i*NUM_BYTES +: NUM_BYTES];
        w_sel_last  = s_last[i];
        w_sel_user  = s_user[i*USER_BITS +: USER_BITS];
      end
    end
  end

  // Steer downstream ready to the granted input only, and only while a packet is locked.
  always_comb begin
    w_ready = '0;
    if (r_state == ST_LOCKED) begin
      w_ready[r_grant] = m_ready;
    end
  end

  // Arbitration FSM: grab a winner in IDLE, hold it through the last word, then rotate priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= GW'(NUM_INPUTS - 1);
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_grant <= w_winner;
            r_state <= ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          // Gaps in the granted s_valid keep the lock; only an accepted last word releases it.
          if (w_sel_valid && m_ready && w_sel_last) begin
            r_rr_ptr <= r_grant;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign m_valid = (r_state == ST_LOCKED) && w_sel_valid;
  assign m_data  = w_sel_data;
  assign m_keep  = w_sel_keep;
  assign m_last  = w_sel_last;
  assign m_user  = w_sel_user;
  assign s_ready = w_ready;
  assign grant   = r_grant;
  assign busy    = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_ss_pkt_arbiter.sv
module tb_ss_pkt_arbiter;

  localparam int NI = 4;
  localparam int NB = 1;
  localparam int UB = 1;
  localparam int DW = NB * 8;

  typedef struct packed {
    logic          last;
    logic [UB-1:0] user;
    logic [NB-1:0] keep;
    logic [DW-1:0] data;
  } word_t;

  typedef struct {
    logic [1:0] g;
    word_t      w;
    int         cyc;
  } ent_t;

  logic              clk;
  logic              rst;
  logic [NI-1:0]     s_valid;
  logic [NI-1:0]     s_ready;
  logic [NI*DW-1:0]  s_data;
  logic [NI*NB-1:0]  s_keep;
  logic [NI-1:0]     s_last;
  logic [NI*UB-1:0]  s_user;
  logic              m_valid;
  logic              m_ready;
  logic [DW-1:0]     m_data;
  logic [NB-1:0]     m_keep;
  logic              m_last;
  logic [UB-1:0]     m_user;
  logic [1:0]        grant;
  logic              busy;

  ss_pkt_arbiter #(.NUM_INPUTS(NI), .NUM_BYTES(NB), .USER_BITS(UB)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_keep(s_keep),
    .s_last(s_last), .s_user(s_user),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_keep(m_keep),
    .m_last(m_last), .m_user(m_user), .grant(grant), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  word_t         src_q[NI][$];
  word_t         exp_q[NI][$];
  ent_t          log_q[$];
  logic [NI-1:0] hold;
  logic          tb_mready;
  int            cyc;
  int            n_checks;
  int            n_fail;

  logic          obs_mvalid;
  logic [NI-1:0] obs_sready;
  logic          obs_busy;
  logic [1:0]    obs_grant;
  logic [DW-1:0] obs_mdata;
  logic          obs_mlast;

  // One clock cycle of source/sink model: drive after the edge, sample at negedge.
  task automatic step();
    for (int i = 0; i < NI; i++) begin
      if (src_q[i].size() > 0 && !hold[i]) begin
        s_valid[i] = 1'b1;
        s_data[i*DW +: DW] = src_q[i][0].data;
        s_keep[i*NB +: NB] = src_q[i][0].keep;
        s_user[i*UB +: UB] = src_q[i][0].user;
        s_last[i] = src_q[i][0].last;
      end else begin
        s_valid[i] = 1'b0;
        s_data[i*DW +: DW] = '0;
        s_keep[i*NB +: NB] = '0;
        s_user[i*UB +: UB] = '0;
        s_last[i] = 1'b0;
      end
    end
    m_ready = tb_mready;
    @(negedge clk);
    obs_mvalid = m_valid;
    obs_sready = s_ready;
    obs_busy   = busy;
    obs_grant  = grant;
    obs_mdata  = m_data;
    obs_mlast  = m_last;
    if (m_valid && m_ready)
      log_q.push_back('{g: grant, w: {m_last, m_user, m_keep, m_data}, cyc: cyc});
    if (!rst) begin
      for (int i = 0; i < NI; i++)
        if (s_valid[i] && s_ready[i]) void'(src_q[i].pop_front());
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_srcs();
    for (int i = 0; i < NI; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
    end
    hold = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_srcs();
    tb_mready = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    log_q.delete();
  endtask

  task automatic push_word(input int i, input logic [7:0] d, input logic l);
    word_t w;
    w.data = d;
    w.keep = 1'b1;
    w.user = 1'b0;
    w.last = l;
    src_q[i].push_back(w);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < NI; i++) push_word(i, 8'(i), 1'b1);
    step();
    step();
    n_checks++; if (obs_mvalid !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid got %b exp 0", obs_mvalid); end
    n_checks++; if (obs_sready !== 4'b0000) begin n_fail++; $display("FAIL rst_s_ready got %b exp 0000", obs_sready); end
    n_checks++; if (obs_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", obs_busy); end
    n_checks++; if (obs_grant !== 2'd0) begin n_fail++; $display("FAIL rst_grant got %0d exp 0", obs_grant); end
    do_reset();
  endtask

  task automatic test_round_robin();
    int pkt, inp, p;
    logic [7:0] ed;
    do_reset();
    for (int i = 0; i < NI; i++)
      for (int pp = 0; pp < 2; pp++)
        for (int w = 0; w < 3; w++) push_word(i, 8'(i*16 + pp*4 + w), w == 2);
    for (int n = 0; n < 40 && log_q.size() < 15; n++) step();
    n_checks++;
    if (log_q.size() < 15) begin n_fail++; $display("FAIL rr_timeout got %0d words exp 15", log_q.size()); end
    for (int k = 0; k < 15 && k < log_q.size(); k++) begin
      pkt = k / 3;
      inp = pkt % 4;
      p   = pkt / 4;
      ed  = 8'(inp*16 + p*4 + k%3);
      n_checks++; if (log_q[k].g !== 2'(inp)) begin n_fail++; $display("FAIL rr_grant k=%0d got %0d exp %0d", k, log_q[k].g, inp); end
      n_checks++; if (log_q[k].w.data !== ed) begin n_fail++; $display("FAIL rr_data k=%0d got %h exp %h", k, log_q[k].w.data, ed); end
      n_checks++; if (log_q[k].w.last !== (k%3 == 2)) begin n_fail++; $display("FAIL rr_last k=%0d got %b", k, log_q[k].w.last); end
      n_checks++; if (log_q[k].cyc - log_q[0].cyc !== k + k/3) begin n_fail++; $display("FAIL rr_timing k=%0d got %0d exp %0d", k, log_q[k].cyc - log_q[0].cyc, k + k/3); end
    end
  endtask

  task automatic test_single_input();
    logic exp_mv;
    do_reset();
    push_word(2, 8'h21, 1'b1);
    push_word(2, 8'h22, 1'b1);
    for (int s = 0; s < 4; s++) begin
      step();
      exp_mv = (s == 1 || s == 3);
      n_checks++; if (obs_mvalid !== exp_mv) begin n_fail++; $display("FAIL single_m_valid s=%0d got %b exp %b", s, obs_mvalid, exp_mv); end
      n_checks++; if (obs_sready !== (exp_mv ? 4'b0100 : 4'b0000)) begin n_fail++; $display("FAIL single_s_ready s=%0d got %b", s, obs_sready); end
      n_checks++; if (obs_busy !== exp_mv) begin n_fail++; $display("FAIL single_busy s=%0d got %b exp %b", s, obs_busy, exp_mv); end
      if (exp_mv) begin
        n_checks++; if (obs_grant !== 2'd2) begin n_fail++; $display("FAIL single_grant s=%0d got %0d exp 2", s, obs_grant); end
      end
    end
  endtask

  task automatic test_stall();
    logic       mr_seq[9];
    logic [7:0] d_seq[9];
    mr_seq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    d_seq  = '{8'h00, 8'hA0, 8'hA1, 8'hA2, 8'hA2, 8'hA2, 8'hA3, 8'h00, 8'hC0};
    do_reset();
    for (int w = 0; w < 4; w++) push_word(1, 8'(8'hA0 + w), w == 3);
    push_word(3, 8'hC0, 1'b1);
    for (int s = 0; s < 9; s++) begin
      tb_mready = mr_seq[s];
      step();
      if (s >= 2 && s <= 5) begin
        n_checks++; if (obs_mvalid !== 1'b1) begin n_fail++; $display("FAIL stall_m_valid s=%0d got %b exp 1", s, obs_mvalid); end
        n_checks++; if (obs_mdata !== d_seq[s]) begin n_fail++; $display("FAIL stall_data s=%0d got %h exp %h", s, obs_mdata, d_seq[s]); end
        n_checks++; if (obs_sready !== (mr_seq[s] ? 4'b0010 : 4'b0000)) begin n_fail++; $display("FAIL stall_s_ready s=%0d got %b", s, obs_sready); end
      end
      if (s == 8) begin
        n_checks++; if (obs_grant !== 2'd3) begin n_fail++; $display("FAIL stall_next_grant got %0d exp 3", obs_grant); end
        n_checks++; if (obs_mdata !== 8'hC0) begin n_fail++; $display("FAIL stall_next_data got %h exp c0", obs_mdata); end
      end
    end
    tb_mready = 1'b1;
  endtask

  task automatic test_gap();
    do_reset();
    for (int w = 0; w < 3; w++) push_word(0, 8'(8'hB0 + w), w == 2);
    push_word(3, 8'hC3, 1'b1);
    for (int s = 0; s < 9; s++) begin
      hold[0] = (s >= 2 && s <= 4);
      step();
      if (s >= 2 && s <= 4) begin
        n_checks++; if (obs_mvalid !== 1'b0) begin n_fail++; $display("FAIL gap_m_valid s=%0d got %b exp 0", s, obs_mvalid); end
        n_checks++; if (obs_grant !== 2'd0) begin n_fail++; $display("FAIL gap_grant s=%0d got %0d exp 0", s, obs_grant); end
        n_checks++; if (obs_busy !== 1'b1) begin n_fail++; $display("FAIL gap_busy s=%0d got %b exp 1", s, obs_busy); end
        n_checks++; if (obs_sready !== 4'b0001) begin n_fail++; $display("FAIL gap_s_ready s=%0d got %b exp 0001", s, obs_sready); end
      end
      if (s == 6) begin
        n_checks++; if (obs_mdata !== 8'hB2 || obs_mlast !== 1'b1) begin n_fail++; $display("FAIL gap_last_word got %h/%b exp b2/1", obs_mdata, obs_mlast); end
      end
      if (s == 7) begin
        n_checks++; if (obs_busy !== 1'b0) begin n_fail++; $display("FAIL gap_idle_busy got %b exp 0", obs_busy); end
      end
      if (s == 8) begin
        n_checks++; if (obs_grant !== 2'd3 || obs_mvalid !== 1'b1 || obs_mdata !== 8'hC3) begin
          n_fail++; $display("FAIL gap_next got grant %0d valid %b data %h exp 3/1/c3", obs_grant, obs_mvalid, obs_mdata);
        end
      end
    end
    hold = '0;
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    push_word(0, 8'hE0, 1'b1);
    step();
    step();
    for (int w = 0; w < 4; w++) push_word(2, 8'(8'hD0 + w), w == 3);
    step();
    step();
    n_checks++; if (obs_grant !== 2'd2 || obs_mdata !== 8'hD0) begin n_fail++; $display("FAIL rmid_first got grant %0d data %h exp 2/d0", obs_grant, obs_mdata); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_srcs();
    step();
    n_checks++; if (obs_mvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_m_valid got %b exp 0", obs_mvalid); end
    n_checks++; if (obs_busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got %b exp 0", obs_busy); end
    n_checks++; if (obs_grant !== 2'd0) begin n_fail++; $display("FAIL rmid_grant got %0d exp 0", obs_grant); end
    push_word(0, 8'hF0, 1'b1);
    push_word(3, 8'hF3, 1'b1);
    step();
    step();
    n_checks++; if (obs_grant !== 2'd0 || obs_mdata !== 8'hF0) begin n_fail++; $display("FAIL rmid_winner got grant %0d data %h exp 0/f0", obs_grant, obs_mdata); end
  endtask

  task automatic test_random();
    int    len;
    int    pending;
    word_t w;
    word_t e;
    do_reset();
    for (int n = 0; n < 10000; n++) begin
      tb_mready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NI; i++) begin
        hold[i] = ($urandom_range(0, 7) == 0);
        if (src_q[i].size() < 6 && $urandom_range(0, 3) == 0) begin
          len = $urandom_range(1, 5);
          for (int k = 0; k < len; k++) begin
            w.data = 8'($urandom);
            w.keep = 1'($urandom);
            w.user = 1'($urandom);
            w.last = (k == len - 1);
            src_q[i].push_back(w);
            exp_q[i].push_back(w);
          end
        end
      end
      step();
    end
    hold = '0;
    tb_mready = 1'b1;
    pending = 1;
    for (int n = 0; n < 2000 && pending != 0; n++) begin
      step();
      pending = 0;
      for (int i = 0; i < NI; i++) pending += src_q[i].size();
    end
    n_checks++; if (pending != 0) begin n_fail++; $display("FAIL rand_drain got %0d words left exp 0", pending); end
    for (int k = 0; k < log_q.size(); k++) begin
      if (k > 0 && !log_q[k-1].w.last) begin
        n_checks++; if (log_q[k].g !== log_q[k-1].g) begin n_fail++; $display("FAIL rand_interleave k=%0d got %0d exp %0d", k, log_q[k].g, log_q[k-1].g); end
      end
      n_checks++;
      if (exp_q[log_q[k].g].size() == 0) begin
        n_fail++; $display("FAIL rand_extra k=%0d input %0d got extra word exp none", k, log_q[k].g);
      end else begin
        e = exp_q[log_q[k].g].pop_front();
        if (log_q[k].w !== e) begin n_fail++; $display("FAIL rand_word k=%0d input %0d got %h exp %h", k, log_q[k].g, log_q[k].w, e); end
      end
    end
    for (int i = 0; i < NI; i++) begin
      n_checks++; if (exp_q[i].size() != 0) begin n_fail++; $display("FAIL rand_missing input %0d got %0d unsent exp 0", i, exp_q[i].size()); end
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    cyc       = 0;
    rst       = 1'b1;
    hold      = '0;
    tb_mready = 1'b1;
    s_valid   = '0;
    s_data    = '0;
    s_keep    = '0;
    s_last    = '0;
    s_user    = '0;
    m_ready   = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_round_robin();
    test_single_input();
    test_stall();
    test_gap();
    test_reset_mid_packet();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
